// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage access engine between the EX/MEM register and the data bus.
//   Formats loads/stores into word-aligned bus transactions with byte enables,
//   extends load data for MEM/WB and stalls the pipeline while a transaction
//   is outstanding.
//
//   Optional feature macro: LSU_TIMEOUT_EN
//     defined   -> REQ gives up after TIMEOUT_CYCLES cycles without bus_ack,
//                  pulses fault, zeroes rdata on a load, and finishes via DONE.
//     undefined -> REQ waits for bus_ack indefinitely; no counter is built.
//
//   Ports:
//     clk, rst (async, active-low), enable
//     mem_rd, mem_wr, funct3, addr, wdata   : EX/MEM access request
//     rdata, stall, fault                    : results to the pipeline
//     bus_req, bus_we, bus_addr, bus_be,
//     bus_wdata, bus_ack, bus_rdata          : data memory bus
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Access attributes latched at issue; bus_addr drops the byte offset.
  logic [1:0] lo_q;
  logic [2:0] f3_q;

  logic        valid;
  logic        is_store;
  logic        legal;
  logic        aligned;
  logic        go;
  logic        err;
  logic [3:0]  be_st;
  logic [31:0] wd_st;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  // Request decode; a store wins when both mem_rd and mem_wr are set.
  always_comb begin
    valid    = (mem_rd | mem_wr) & enable;
    is_store = mem_wr;
    legal    = 1'b0;
    if (is_store) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    go  = valid & legal & aligned;
    err = valid & ~(legal & aligned);
  end

  // Store lane formatting: data replicated across lanes, enables pick the lane.
  always_comb begin
    be_st = 4'b1111;
    wd_st = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_st = 4'b0001 << addr[1:0];
        wd_st = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_st = addr[1] ? 4'b1100 : 4'b0011;
        wd_st = {2{wdata[15:0]}};
      end
      default: begin
        be_st = 4'b1111;
        wd_st = wdata;
      end
    endcase
  end

  // Load lane extraction and extension from the returned word.
  always_comb begin
    case (lo_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'd0, ld_byte};
      3'b101:  load_val = {16'd0, ld_half};
      default: load_val = bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt;
  logic          fault_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rdata     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      lo_q      <= '0;
      f3_q      <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt       <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
`ifdef LSU_TIMEOUT_EN
      fault_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (go) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= is_store ? be_st : 4'b1111;
            bus_wdata <= is_store ? wd_st : '0;
            lo_q      <= addr[1:0];
            f3_q      <= funct3;
            state     <= REQ;
`ifdef LSU_TIMEOUT_EN
            cnt       <= '0;
`endif
          end else if (err && !is_store) begin
            rdata <= '0;
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) rdata <= load_val;
            state <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            bus_req <= 1'b0;
            fault_q <= 1'b1;
            if (!bus_we) rdata <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational outputs are gated by rst so every output reads 0 in reset.
  assign stall = rst & (((state == IDLE) & go) | (state == REQ));
`ifdef LSU_TIMEOUT_EN
  assign fault = rst & (((state == IDLE) & err) | fault_q);
`else
  assign fault = rst & (state == IDLE) & err;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
  load_store_unit dut (
`endif
    .clk(clk), .rst(rst), .enable(enable), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one access in IDLE, acks on REQ cycle ack_at, checks the bus fields
  // in the first REQ cycle and the stall length, and returns in IDLE.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat,
                        input int ack_at, input logic exp_we,
                        input logic [31:0] exp_baddr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
    int stall_cnt;
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    bus_rdata = rdat; enable = 1'b1;
    #1;
    chk({tag, "_idle_req"}, {31'd0, bus_req}, 32'd0);
    stall_cnt = stall ? 1 : 0;
    for (int k = 1; k <= ack_at; k++) begin
      step();
      if (k == 1) begin
        chk({tag, "_req"},   {31'd0, bus_req}, 32'd1);
        chk({tag, "_we"},    {31'd0, bus_we},  {31'd0, exp_we});
        chk({tag, "_baddr"}, bus_addr,         exp_baddr);
        chk({tag, "_be"},    {28'd0, bus_be},  {28'd0, exp_be});
        chk({tag, "_wdata"}, bus_wdata,        exp_wd);
      end
      if (stall) stall_cnt++;
      bus_ack = (k == ack_at);
    end
    step();
    bus_ack = 1'b0;
    chk({tag, "_done_stall"}, {31'd0, stall},   32'd0);
    chk({tag, "_done_req"},   {31'd0, bus_req}, 32'd0);
    chk({tag, "_stall_len"},  stall_cnt,        1 + ack_at);
    mem_rd = 1'b0; mem_wr = 1'b0;
    step();
  endtask

  initial begin
    #3;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_req",   {31'd0, bus_req}, 32'd0);
    chk("rst_be",    {28'd0, bus_be}, 32'd0);
    chk("rst_baddr", bus_addr, 32'd0);
    step();
    rst = 1'b1;
    step();

    access("sw",  1'b0, 1'b1, 3'b010, 32'h100, 32'h12345678, 32'h0, 3, 1'b1, 32'h100, 4'b1111, 32'h12345678);
    access("sb",  1'b0, 1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h0, 1, 1'b1, 32'h100, 4'b1000, 32'hABABABAB);
    access("sh",  1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 2, 1'b1, 32'h100, 4'b1100, 32'hABCDABCD);

    access("lb",  1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h000080FF, 1, 1'b0, 32'h100, 4'b1111, 32'h0);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    access("lbu", 1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 32'h000080FF, 1, 1'b0, 32'h100, 4'b1111, 32'h0);
    chk("lbu_rdata", rdata, 32'h00000080);
    access("lw",  1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h000080FF, 2, 1'b0, 32'h100, 4'b1111, 32'h0);
    chk("lw_rdata", rdata, 32'h000080FF);
    access("lhu", 1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 1, 1'b0, 32'h100, 4'b1111, 32'h0);
    chk("lhu_rdata", rdata, 32'h0000F00D);
    access("lh",  1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 1, 1'b0, 32'h100, 4'b1111, 32'h0);
    chk("lh_rdata", rdata, 32'hFFFF8001);

    // Misaligned halfword load: single-cycle fault, no bus activity, rdata cleared.
    mem_rd = 1'b1; funct3 = 3'b001; addr = 32'h101;
    #1;
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    step();
    mem_rd = 1'b0;
    #1;
    chk("mis_req",   {31'd0, bus_req}, 32'd0);
    chk("mis_fault_end", {31'd0, fault}, 32'd0);
    chk("mis_rdata", rdata, 32'd0);

    // Illegal load funct3 also faults.
    mem_rd = 1'b1; funct3 = 3'b011; addr = 32'h100;
    #1;
    chk("ill_fault", {31'd0, fault}, 32'd1);
    chk("ill_stall", {31'd0, stall}, 32'd0);
    step();
    mem_rd = 1'b0;

    // enable low blocks a new access.
    enable = 1'b0; mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h200;
    #1;
    chk("dis_stall", {31'd0, stall}, 32'd0);
    step();
    chk("dis_req", {31'd0, bus_req}, 32'd0);
    mem_rd = 1'b0; enable = 1'b1;

    access("lw2", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'hDEADBEEF, 2, 1'b0, 32'h200, 4'b1111, 32'h0);
    chk("lw2_rdata", rdata, 32'hDEADBEEF);

    // Asynchronous reset in the middle of REQ.
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h300;
    step();
    chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req",   {31'd0, bus_req}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    step();
    rst = 1'b1;
    mem_rd = 1'b0;
    step();
    access("lw3", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0BADF00D, 1, 1'b0, 32'h300, 4'b1111, 32'h0);
    chk("lw3_rdata", rdata, 32'h0BADF00D);

`ifdef LSU_TIMEOUT_EN
    begin
      int req_cnt = 0;
      bit done = 1'b0;
      mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h400; bus_ack = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        step();
        if (bus_req) req_cnt++;
        else done = 1'b1;
      end
      chk("to_reached", {31'd0, done}, 32'd1);
      chk("to_req_len", req_cnt, 4);
      chk("to_fault", {31'd0, fault}, 32'd1);
      chk("to_stall", {31'd0, stall}, 32'd0);
      chk("to_rdata", rdata, 32'd0);
      mem_rd = 1'b0;
      step();
      chk("to_fault_end", {31'd0, fault}, 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
